queue_counter: RTL

//  Downstream consumer of the sensor FSM's up/down level outputs.
//  - Converts each up/down assertion into exactly one +1/-1 event.
//  - Holds the saturating queue occupancy and drives status flags to the display/alarm logic.
//  - Optionally drives an estimated-wait output.

---
 rtl/queue_pkg.sv | 17 +
 rtl/queue_counter_rise_detect.sv | 19 +
 rtl/queue_counter.sv | 99 +++++++++
 3 files changed

// File: rtl/queue_pkg.sv
// queue_pkg: shared types and default sizing for the queue occupancy counter.
//   DEF_COUNT_W / DEF_CAPACITY / DEF_ALARM_THRESH : default parameter values
//   count_t : occupancy count at default width
//   event_t : per-cycle count action, also consumed by the display block
package queue_pkg;
  localparam int DEF_COUNT_W      = 4;
  localparam int DEF_CAPACITY     = 15;
  localparam int DEF_ALARM_THRESH = 12;

  typedef logic [DEF_COUNT_W-1:0] count_t;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_INC  = 2'd1,
    EV_DEC  = 2'd2
  } event_t;
endpackage

// File: rtl/queue_counter_rise_detect.sv
// rise_detect: one-pulse-per-assertion edge detector for a level input.
//   clk, rst (async, active low), lvl (level in), evt (1-cycle pulse on 0->1)
// The history register resets to 1 so a level already high when reset
// releases is treated as old and produces no event.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic evt
);
  logic lvl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lvl_q <= 1'b1;
    else      lvl_q <= lvl;
  end

  assign evt = lvl & ~lvl_q;
endmodule

// File: rtl/queue_counter.sv
// queue_counter: saturating queue occupancy counter fed by sensor FSM levels.
//   clk, rst (async, active low)
//   up / down  : levels held while the sensor FSM is in UPSTATE / DOWNSTATE
//   clr_err    : synchronous clear of the sticky error flags
//   count      : occupancy; empty / full / alarm decoded from it
//   ovf_err    : sticky, up event while full
//   unf_err    : sticky, down event while empty
//   wait_time  : count*SERVICE_TIME saturated (only with QUEUE_WAIT_EST_EN)
// Optional feature macro: QUEUE_WAIT_EST_EN.
module queue_counter
  import queue_pkg::*;
#(
  parameter int COUNT_W      = DEF_COUNT_W,
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int ALARM_THRESH = DEF_ALARM_THRESH,
  parameter int SERVICE_TIME = 30,
  parameter int WAIT_W       = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up,
  input  logic               down,
  input  logic               clr_err,
  output logic [COUNT_W-1:0] count,
  output logic               empty,
  output logic               full,
  output logic               alarm,
  output logic               ovf_err,
`ifdef QUEUE_WAIT_EST_EN
  output logic               unf_err,
  output logic [WAIT_W-1:0]  wait_time
`else
  output logic               unf_err
`endif
);
  localparam logic [COUNT_W-1:0] CAP = COUNT_W'(CAPACITY);
  localparam logic [COUNT_W-1:0] THR = COUNT_W'(ALARM_THRESH);

  logic up_evt, dn_evt;

  rise_detect u_up_det (.clk(clk), .rst(rst), .lvl(up),   .evt(up_evt));
  rise_detect u_dn_det (.clk(clk), .rst(rst), .lvl(down), .evt(dn_evt));

  event_t             ev;
  logic               ovf_hit, unf_hit;
  logic [COUNT_W-1:0] count_next;

  // Coincident up and down events cancel: no change, no error.
  always_comb begin
    ev      = EV_NONE;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    if (up_evt && !dn_evt) begin
      if (count == CAP) ovf_hit = 1'b1;
      else              ev      = EV_INC;
    end else if (dn_evt && !up_evt) begin
      if (count == '0)  unf_hit = 1'b1;
      else              ev      = EV_DEC;
    end
    count_next = count;
    case (ev)
      EV_INC:  count_next = count + 1'b1;
      EV_DEC:  count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // A fresh error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      count   <= count_next;
      ovf_err <= (ovf_err & ~clr_err) | ovf_hit;
      unf_err <= (unf_err & ~clr_err) | unf_hit;
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CAP);
  assign alarm = (count >= THR);

`ifdef QUEUE_WAIT_EST_EN
  // Product is wide enough for any count times a 32-bit service time.
  localparam int                PW   = COUNT_W + 32;
  localparam logic [PW-1:0]     WMAX = PW'((64'd1 << WAIT_W) - 64'd1);
  logic [PW-1:0] prod;

  assign prod = PW'(count_next) * PW'(SERVICE_TIME);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             wait_time <= '0;
    else if (prod > WMAX) wait_time <= '1;
    else                  wait_time <= prod[WAIT_W-1:0];
  end
`endif
endmodule
